// File: rtl/timer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_pkg: register map, bit positions, bus FSM encoding and reset constants
// Revision: 1.0
// ----------------------------------------------------------------------------
package timer_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int unsigned CTRL_EN_BIT          = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT      = 1;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 2;
    localparam int unsigned STATUS_MATCH_BIT     = 0;

    // COMPARE resets to all ones; replicated to the data width at the use site.
    localparam logic COMPARE_RESET_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_core: enable-gated counter with compare, auto-reload and sticky match
// Revision: 1.0
// ----------------------------------------------------------------------------
module timer_core
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  auto_reload_i,
    input  logic [DATA_WIDTH-1:0] compare_i,
    input  logic                  count_we_i,
    input  logic [DATA_WIDTH-1:0] count_wdata_i,
    input  logic                  match_clr_i,
    output logic [DATA_WIDTH-1:0] count_o,
    output logic                  match_o
);

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] count_d;
    logic                  match_q;
    logic                  match_d;
    logic                  hit;

    always_comb begin
        hit     = en_i && (count_q == compare_i);
        count_d = count_q;
        // A bus write outranks both reload and increment.
        if (count_we_i) begin
            count_d = count_wdata_i;
        end else if (hit && auto_reload_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_ONE;
        end

        match_d = match_q;
        if (match_clr_i) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            match_q <= match_d;
        end
    end

    assign count_o = count_q;
    assign match_o = match_q;

endmodule : timer_core
`default_nettype wire

// File: rtl/timer_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_responder: bus-mapped timer with four-state request/response handshake
// Revision: 1.0
// ----------------------------------------------------------------------------
module timer_responder
    import timer_pkg::*;
#(
    parameter int          MEM_DEPTH  = 64,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 60,
    localparam int         ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  req_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  data_valid,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] BASE_VEC = BASE_ADDR[ADDR_WIDTH-1:0];

    bus_state_e            state_q;
    logic [1:0]            off_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsample_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  data_valid_q;
    ctrl_t                 ctrl_q;
    logic [DATA_WIDTH-1:0] compare_q;

    logic                  hit;
    logic                  wr_ctrl;
    logic                  wr_count;
    logic                  wr_compare;
    logic                  wr_status;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] count;
    logic                  match;

    // BASE_ADDR is word-aligned to 4, so the register offset is just addr[1:0].
    assign hit = (addr[ADDR_WIDTH-1:2] == BASE_VEC[ADDR_WIDTH-1:2]);

    always_comb begin
        wr_ctrl    = 1'b0;
        wr_count   = 1'b0;
        wr_compare = 1'b0;
        wr_status  = 1'b0;
        if (state_q == ST_ACCESS && we_q) begin
            wr_ctrl    = (off_q == REG_CTRL);
            wr_count   = (off_q == REG_COUNT);
            wr_compare = (off_q == REG_COMPARE);
            wr_status  = (off_q == REG_STATUS);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (off_q)
            REG_CTRL: begin
                rd_mux[CTRL_EN_BIT]          = ctrl_q.en;
                rd_mux[CTRL_IRQ_EN_BIT]      = ctrl_q.irq_en;
                rd_mux[CTRL_AUTO_RELOAD_BIT] = ctrl_q.auto_reload;
            end
            REG_COUNT:   rd_mux = count;
            REG_COMPARE: rd_mux = compare_q;
            REG_STATUS:  rd_mux[STATUS_MATCH_BIT] = match;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            off_q        <= 2'd0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rsample_q    <= '0;
            rdata_q      <= '0;
            data_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_valid_q <= 1'b0;
                    rdata_q      <= '0;
                    if (req_valid && hit) begin
                        state_q <= ST_ACCESS;
                        off_q   <= addr[1:0];
                        we_q    <= we;
                        wdata_q <= wdata;
                    end
                end
                ST_ACCESS: begin
                    rsample_q <= we_q ? '0 : rd_mux;
                    state_q   <= ST_RESP;
                end
                ST_RESP: begin
                    data_valid_q <= 1'b1;
                    rdata_q      <= rsample_q;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    data_valid_q <= 1'b0;
                    rdata_q      <= '0;
                    // Holding req_valid after the response must not start a new access.
                    if (!req_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            compare_q <= {DATA_WIDTH{COMPARE_RESET_BIT}};
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= '{auto_reload: wdata_q[CTRL_AUTO_RELOAD_BIT],
                            irq_en:      wdata_q[CTRL_IRQ_EN_BIT],
                            en:          wdata_q[CTRL_EN_BIT]};
            end
            if (wr_compare) begin
                compare_q <= wdata_q;
            end
        end
    end

    timer_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .en_i          (ctrl_q.en),
        .auto_reload_i (ctrl_q.auto_reload),
        .compare_i     (compare_q),
        .count_we_i    (wr_count),
        .count_wdata_i (wdata_q),
        .match_clr_i   (wr_status && wdata_q[STATUS_MATCH_BIT]),
        .count_o       (count),
        .match_o       (match)
    );

    assign rdata      = rdata_q;
    assign data_valid = data_valid_q;
    assign irq        = match && ctrl_q.irq_en;

endmodule : timer_responder
`default_nettype wire

// File: tb/tb_timer_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_timer_responder: directed checks of the timer responder bus and counter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_timer_responder;

    logic        clk;
    logic        reset;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        req_valid;
    logic [31:0] rdata;
    logic        data_valid;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_responder #(
        .MEM_DEPTH  (64),
        .DATA_WIDTH (32),
        .BASE_ADDR  (60)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .req_valid  (req_valid),
        .rdata      (rdata),
        .data_valid (data_valid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        req_valid = 1'b0;
        we        = 1'b0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // One full handshake; l counts edges until data_valid, capped at 10 when no response arrives.
    task automatic bus_xfer(input logic [5:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] r, output int l);
        addr = a; we = w; wdata = d; req_valid = 1'b1;
        l = 0;
        r = '0;
        while (l < 10) begin
            @(posedge clk); #1;
            l++;
            if (data_valid) break;
        end
        r = rdata;
        req_valid = 1'b0;
        we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        logic [31:0] exp_v [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        apply_reset();
        addr = 6'd62; we = 1'b0; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_dv: got %b want 1", data_valid); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL async_reset_dv: got %b want 0", data_valid); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL async_reset_rdata: got %h want 0", rdata); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b want 0", irq); end
        req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus_xfer(6'(60 + i), 1'b0, 32'h0, rd, lat);
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL reset_read_lat[%0d]: got %0d want 3", i, lat); end
            checks++;
            if (rd !== exp_v[i]) begin errors++; $display("FAIL reset_value[%0d]: got %h want %h", i, rd, exp_v[i]); end
        end
    endtask

    task automatic test_match_no_irq();
        logic [31:0] rd;
        int lat;
        int   exp_cnt [5] = '{3, 4, 5, 6, 7};
        logic exp_m   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        bus_xfer(6'd62, 1'b1, 32'd5, rd, lat);
        bus_xfer(6'd60, 1'b1, 32'h1, rd, lat);
        checks++;
        if (dut.u_core.count_q !== 32'd2) begin errors++; $display("FAIL match_start_count: got %0d want 2", dut.u_core.count_q); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dut.u_core.count_q !== 32'(exp_cnt[i])) begin
                errors++; $display("FAIL match_count[%0d]: got %0d want %0d", i, dut.u_core.count_q, exp_cnt[i]);
            end
            checks++;
            if (dut.u_core.match_q !== exp_m[i]) begin
                errors++; $display("FAIL match_flag[%0d]: got %b want %b", i, dut.u_core.match_q, exp_m[i]);
            end
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL match_irq_off[%0d]: got %b want 0", i, irq); end
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] rd;
        int lat;
        int   exp_cnt [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
        logic exp_m   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        apply_reset();
        bus_xfer(6'd62, 1'b1, 32'd3, rd, lat);
        bus_xfer(6'd60, 1'b1, 32'h7, rd, lat);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dut.u_core.count_q !== 32'(exp_cnt[i])) begin
                errors++; $display("FAIL reload_count[%0d]: got %0d want %0d", i, dut.u_core.count_q, exp_cnt[i]);
            end
            checks++;
            if (irq !== exp_m[i]) begin errors++; $display("FAIL reload_irq[%0d]: got %b want %b", i, irq, exp_m[i]); end
        end
        bus_xfer(6'd60, 1'b1, 32'h6, rd, lat);
        addr = 6'd63; we = 1'b1; wdata = 32'h1; req_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_before: got %b want 1", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_after: got %b want 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (data_valid !== 1'b1) begin errors++; $display("FAIL w1c_dv: got %b want 1", data_valid); end
        req_valid = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_hold();
        logic [31:0] rd;
        int lat;
        apply_reset();
        bus_xfer(6'd61, 1'b1, 32'd100, rd, lat);
        addr = 6'd61; we = 1'b0; req_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (data_valid !== (i == 3)) begin
                errors++; $display("FAIL hold_dv[%0d]: got %b want %b", i, data_valid, (i == 3));
            end
            checks++;
            if (rdata !== ((i == 3) ? 32'd100 : 32'd0)) begin
                errors++; $display("FAIL hold_rdata[%0d]: got %h want %h", i, rdata, ((i == 3) ? 32'd100 : 32'd0));
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_miss();
        logic [31:0] rd;
        int lat;
        int dv_seen;
        logic [5:0]  miss_a [2] = '{6'd12, 6'd58};
        logic [31:0] exp_v  [4] = '{32'h0, 32'h0, 32'h1234, 32'h0};
        apply_reset();
        bus_xfer(6'd62, 1'b1, 32'h1234, rd, lat);
        for (int m = 0; m < 2; m++) begin
            addr = miss_a[m]; we = 1'b1; wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
            dv_seen = 0;
            repeat (8) begin
                @(posedge clk); #1;
                if (data_valid) dv_seen++;
            end
            checks++;
            if (dv_seen !== 0) begin errors++; $display("FAIL miss_dv[%0d]: got %0d responses want 0", m, dv_seen); end
            req_valid = 1'b0; we = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            bus_xfer(6'(60 + i), 1'b0, 32'h0, rd, lat);
            checks++;
            if (rd !== exp_v[i]) begin errors++; $display("FAIL miss_reg[%0d]: got %h want %h", i, rd, exp_v[i]); end
        end
    endtask

    task automatic test_wrap_w1c();
        logic [31:0] rd;
        int lat;
        apply_reset();
        bus_xfer(6'd60, 1'b1, 32'h1, rd, lat);
        checks++;
        if (dut.u_core.count_q !== 32'd2) begin errors++; $display("FAIL wrap_start: got %0d want 2", dut.u_core.count_q); end
        addr = 6'd61; we = 1'b1; wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (dut.u_core.count_q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_load: got %h want ffffffff", dut.u_core.count_q); end
        @(posedge clk); #1;
        checks++;
        if (dut.u_core.count_q !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", dut.u_core.count_q); end
        checks++;
        if (dut.u_core.match_q !== 1'b1) begin errors++; $display("FAIL wrap_match: got %b want 1", dut.u_core.match_q); end
        req_valid = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        bus_xfer(6'd63, 1'b1, 32'h1, rd, lat);
        checks++;
        if (dut.u_core.match_q !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b want 0", dut.u_core.match_q); end
        bus_xfer(6'd62, 1'b1, 32'd10, rd, lat);
        bus_xfer(6'd63, 1'b1, 32'h1, rd, lat);
        checks++;
        if (dut.u_core.match_q !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", dut.u_core.match_q); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_off: got %b want 0", irq); end
        bus_xfer(6'd63, 1'b1, 32'h0, rd, lat);
        checks++;
        if (dut.u_core.match_q !== 1'b1) begin errors++; $display("FAIL w0_no_effect: got %b want 1", dut.u_core.match_q); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        apply_reset();
        addr = 6'd62; we = 1'b1; wdata = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_dv: got %b want 0", data_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0; we = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        bus_xfer(6'd62, 1'b0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_reset_compare: got %h want ffffffff", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        apply_reset();
        bus_xfer(6'd62, 1'b1, 32'hA5A5_0001, rd, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL b2b_write_lat: got %0d want 3", lat); end
        bus_xfer(6'd62, 1'b0, 32'h0, rd, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL b2b_read_lat: got %0d want 3", lat); end
        checks++;
        if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_readback: got %h want a5a50001", rd); end
        bus_xfer(6'd60, 1'b1, 32'hFFFF_FFFE, rd, lat);
        bus_xfer(6'd60, 1'b0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL ctrl_mask: got %h want 6", rd); end
    endtask

    initial begin
        reset = 1'b0; addr = '0; wdata = '0; we = 1'b0; req_valid = 1'b0;
        test_reset();
        test_match_no_irq();
        test_auto_reload();
        test_read_hold();
        test_miss();
        test_wrap_w1c();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_timer_responder
`default_nettype wire

// File: doc/timer_responder.md
TIMER_RESPONDER -- requirements
Module: timer_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 64, sets the bus address space; ADDR_WIDTH = clog2(MEM_DEPTH).
REQ-002 Parameter DATA_WIDTH, default 32, sets the bus data and timer width.
REQ-003 Parameter BASE_ADDR, default 60, is the word address of register 0 and SHALL be a multiple of 4.
REQ-004 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 addr  input  ADDR_WIDTH  word address from the initiator.
REQ-007 wdata  input  DATA_WIDTH  write data from the initiator.
REQ-008 we  input  1  1 = write, 0 = read; qualified by req_valid.
REQ-009 req_valid  input  1  initiator request, held until data_valid is seen.
REQ-010 rdata  output  DATA_WIDTH  read data; valid only while data_valid=1, else 0.
REQ-011 data_valid  output  1  one-cycle response/acknowledge for a selected request.
REQ-012 irq  output  1  level interrupt = STATUS.match AND CTRL.irq_en.

Function
REQ-013 Register map, offset = addr - BASE_ADDR: 0 CTRL (bit0 en, bit1 irq_en, bit2 auto_reload; other bits read 0), 1 COUNT, 2 COMPARE, 3 STATUS (bit0 match, write-1-to-clear).
REQ-014 Hit condition: addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2].
REQ-015 A request that misses SHALL get no response and SHALL NOT change any state.
REQ-016 The bus FSM SHALL have four states: IDLE, ACCESS, RESP and DONE.
REQ-017 IDLE -> ACCESS when req_valid=1 and the request hits; addr, we and wdata are latched.
REQ-018 ACCESS -> RESP always. A write commits in ACCESS; a read samples the register in ACCESS into an output register.
REQ-019 RESP drives data_valid=1 for exactly one cycle, then -> DONE.
REQ-020 DONE -> IDLE when req_valid=0. Back-to-back requests without req_valid dropping for at least one cycle SHALL NOT be accepted.
REQ-021 Fixed latency: data_valid is asserted 2 cycles after the accepting edge.
REQ-022 When en=1, COUNT increments by 1 each cycle and wraps from 2^DATA_WIDTH-1 to 0.
REQ-023 When en=0, COUNT holds.
REQ-024 When en=1 and COUNT == COMPARE, STATUS.match is set at the next edge.
REQ-025 On that same match, COUNT loads 0 if auto_reload=1; otherwise COUNT keeps incrementing.
REQ-026 A bus write to COUNT SHALL override both the increment and the reload in that cycle.
REQ-027 A W1C write to STATUS in the same cycle as a new match SHALL leave match=1 (set wins).
REQ-028 Writing 0 to STATUS bit0 SHALL have no effect.
REQ-029 A read of COUNT returns the value before that cycle's increment.
REQ-030 irq SHALL be combinational from the registered STATUS.match and CTRL.irq_en, with no added latency.

Reset
REQ-031 On reset low, immediately: FSM=IDLE, data_valid=0, rdata=0, irq=0, CTRL=0, COUNT=0, COMPARE=all ones, STATUS=0.
REQ-032 A reset asserted mid-transaction SHALL abort it with no write committed after the reset edge; the initiator re-issues the request.

Structure
REQ-033 A shared package timer_pkg SHALL hold the register offsets, CTRL/STATUS bit indices, FSM state encoding and the COMPARE reset value.
REQ-034 The counter, compare and match logic SHALL be in one sub-module, timer_core; the bus FSM, decode and register file stay in timer_responder.

Verification
REQ-035 Write CTRL=0x1, COMPARE=5, then wait: match=1 exactly one cycle after COUNT==5; irq stays 0 because irq_en=0.
REQ-036 Write CTRL=0x7, COMPARE=3: COUNT sequence is 0,1,2,3,0,1...; irq=1 after the first match; writing STATUS=1 clears irq within 1 cycle.
REQ-037 Read at addr=61 (COUNT) with req_valid held: data_valid is high for one cycle, 2 cycles after acceptance; rdata is 0 outside that cycle; no second response while req_valid stays high.
REQ-038 Request at addr=12 (miss): data_valid never asserts; all registers are unchanged.
REQ-039 Write COUNT=2^32-1 with en=1: COUNT reads 0 one cycle later; a same-cycle W1C on STATUS and a new match leaves match=1.
REQ-040 Assert reset while in ACCESS on a write of COMPARE=9: data_valid=0 immediately; COMPARE reads all ones afterwards.
